// File: rtl/csr_trap_unit_pkg.sv
// Shared types and CSR address map for the machine-mode CSR file / trap sequencer.
package csr_trap_unit_pkg;

  localparam int unsigned ECAUSE_W = 4;

  typedef enum logic [ECAUSE_W-1:0] {
    EC_INSN_MISALIGN  = 4'd0,
    EC_INSN_ACCESS    = 4'd1,
    EC_ILLEGAL_INSN   = 4'd2,
    EC_BREAKPOINT     = 4'd3,
    EC_LOAD_MISALIGN  = 4'd4,
    EC_LOAD_ACCESS    = 4'd5,
    EC_STORE_MISALIGN = 4'd6,
    EC_STORE_ACCESS   = 4'd7,
    EC_ECALL_M        = 4'd11
  } ecause_t;

  typedef enum logic [1:0] {
    CSR_READ  = 2'd0,
    CSR_WRITE = 2'd1,
    CSR_SET   = 2'd2,
    CSR_CLEAR = 2'd3
  } csr_op_t;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  // RV32I, single hart 0
  localparam logic [31:0] MISA_VALUE    = 32'h4000_0100;
  localparam logic [31:0] MHARTID_VALUE = 32'h0000_0000;

  function automatic logic [31:0] csr_apply(csr_op_t op, logic [31:0] old, logic [31:0] arg);
    case (op)
      CSR_WRITE: return arg;
      CSR_SET:   return old | arg;
      CSR_CLEAR: return old & ~arg;
      default:   return old;
    endcase
  endfunction

endpackage

// File: rtl/csr_trap_unit_counter64.sv
// 64-bit CSR counter with 32-bit half writes; a write to either half suppresses that cycle's increment.
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);

  logic [63:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (wr_lo_i)      cnt_d[31:0]  = wdata_i;
    else if (wr_hi_i) cnt_d[63:32] = wdata_i;
    else if (inc_i)   cnt_d        = cnt_q + 64'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign value_o = cnt_q;

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap/flush sequencer with fetch redirect.
// Optional mcycle/minstret counters when CSR_COUNTERS_EN is defined.
module csr_trap_unit
  import csr_trap_unit_pkg::*;
#(
  parameter int unsigned KILL_CYCLES = 2,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        clk_core,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic        wb_exc,
  input  ecause_t     wb_exc_cause,
  input  logic        wb_flush,
  input  logic [29:0] wb_pc,
  input  logic        wb_stall,
  input  logic        csr_req,
  input  csr_op_t     csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  output logic        csr_kill,
  output logic        csr_redirect,
  output logic [29:0] csr_redirect_pc
);

  typedef enum logic {ST_RUN, ST_KILL} state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                mie_q, mie_d, mpie_q, mpie_d;
  logic [29:0]         mtvec_q, mtvec_d, mepc_q, mepc_d;
  logic [ECAUSE_W-1:0] mcause_q, mcause_d;
  logic [31:0]         mscratch_q, mscratch_d;
  logic                redirect_q, redirect_d;
  logic [29:0]         redirect_pc_q, redirect_pc_d;

  logic        take, flush, known, read_only, csr_we;
  logic [31:0] wval;

  assign take     = (state_q == ST_RUN) & ~wb_stall & wb_exc;
  assign flush    = (state_q == ST_RUN) & ~wb_stall & wb_valid & wb_flush & ~wb_exc;
  assign csr_kill = take | flush | (state_q == ST_KILL);

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle, minstret;

  csr_counter64 u_mcycle (
    .clk_i   (clk_core),
    .rst_i   (reset),
    .inc_i   (1'b1),
    .wr_lo_i (csr_we && csr_addr == CSR_MCYCLE),
    .wr_hi_i (csr_we && csr_addr == CSR_MCYCLEH),
    .wdata_i (wval),
    .value_o (mcycle)
  );

  csr_counter64 u_minstret (
    .clk_i   (clk_core),
    .rst_i   (reset),
    .inc_i   (wb_valid & ~wb_stall & ~csr_kill),
    .wr_lo_i (csr_we && csr_addr == CSR_MINSTRET),
    .wr_hi_i (csr_we && csr_addr == CSR_MINSTRETH),
    .wdata_i (wval),
    .value_o (minstret)
  );
`endif

  always_comb begin
    known     = 1'b1;
    read_only = 1'b0;
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  csr_rdata = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};
      CSR_MISA:     begin csr_rdata = MISA_VALUE;    read_only = 1'b1; end
      CSR_MTVEC:    csr_rdata = {mtvec_q, 2'b00};
      CSR_MSCRATCH: csr_rdata = mscratch_q;
      CSR_MEPC:     csr_rdata = {mepc_q, 2'b00};
      CSR_MCAUSE:   csr_rdata = {{(32-ECAUSE_W){1'b0}}, mcause_q};
      CSR_MHARTID:  begin csr_rdata = MHARTID_VALUE; read_only = 1'b1; end
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE:    csr_rdata = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata = minstret[31:0];
      CSR_MINSTRETH: csr_rdata = minstret[63:32];
`endif
      default:      known = 1'b0;
    endcase
  end

  assign csr_illegal = ~known | (read_only & (csr_op != CSR_READ));
  assign csr_we      = csr_req & ~csr_kill & ~csr_illegal & (csr_op != CSR_READ);
  assign wval        = csr_apply(csr_op, csr_rdata, csr_wdata);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mscratch_d    = mscratch_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;

    if (csr_we) begin
      case (csr_addr)
        CSR_MSTATUS:  begin mie_d = wval[3]; mpie_d = wval[7]; end
        CSR_MTVEC:    mtvec_d    = wval[31:2];
        CSR_MSCRATCH: mscratch_d = wval;
        CSR_MEPC:     mepc_d     = wval[31:2];
        CSR_MCAUSE:   mcause_d   = wval[ECAUSE_W-1:0];
        default:      ;
      endcase
    end

    // csr_we is already blocked by csr_kill here, so the trap update cannot collide with a write
    if (take) begin
      mepc_d        = wb_pc;
      mcause_d      = wb_exc_cause;
      mpie_d        = mie_q;
      mie_d         = 1'b0;
      redirect_d    = 1'b1;
      redirect_pc_d = mtvec_q;
    end else if (flush) begin
      redirect_d    = 1'b1;
      redirect_pc_d = wb_pc + 30'd1;
    end

    case (state_q)
      ST_RUN: begin
        if ((take | flush) && KILL_CYCLES > 1) begin
          state_d = ST_KILL;
          cnt_d   = 3'(KILL_CYCLES - 1);
        end
      end
      ST_KILL: begin
        if (cnt_q == 3'd1) state_d = ST_RUN;
        else               cnt_d   = cnt_q - 3'd1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk_core or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RUN;
      cnt_q         <= '0;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RESET[31:2];
      mepc_q        <= '0;
      mcause_q      <= '0;
      mscratch_q    <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mscratch_q    <= mscratch_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign csr_redirect    = redirect_q;
  assign csr_redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Randomized self-checking bench for csr_trap_unit against an architectural CSR/trap model.
// Build with CSR_COUNTERS_EN defined to cover the counter CSRs.
module tb_csr_trap_unit;
  import csr_trap_unit_pkg::*;

  localparam int unsigned KC = 2;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0100;

  logic        clk_core = 1'b0;
  logic        reset;
  logic        wb_valid, wb_exc, wb_flush, wb_stall;
  ecause_t     wb_exc_cause;
  logic [29:0] wb_pc;
  logic        csr_req;
  csr_op_t     csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal, csr_kill, csr_redirect;
  logic [29:0] csr_redirect_pc;

  csr_trap_unit #(.KILL_CYCLES(KC), .MTVEC_RESET(MTVEC_RST)) dut (
    .clk_core(clk_core), .reset(reset),
    .wb_valid(wb_valid), .wb_exc(wb_exc), .wb_exc_cause(wb_exc_cause),
    .wb_flush(wb_flush), .wb_pc(wb_pc), .wb_stall(wb_stall),
    .csr_req(csr_req), .csr_op(csr_op), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_illegal(csr_illegal), .csr_kill(csr_kill),
    .csr_redirect(csr_redirect), .csr_redirect_pc(csr_redirect_pc)
  );

  always #5 clk_core = ~clk_core;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Architectural model: CSR values held as read-visible words with a writable-bit mask.
  bit [31:0]       m_csr  [bit [11:0]];
  bit [31:0]       m_mask [bit [11:0]];
  longint unsigned m_cyc, m_ins;
  int              m_kill_rem;
  bit              m_redir;
  bit [29:0]       m_rpc;

  function automatic bit is_counter(bit [11:0] a);
    return a == 12'hB00 || a == 12'hB80 || a == 12'hB02 || a == 12'hB82;
  endfunction

  function automatic bit m_known(bit [11:0] a);
`ifdef CSR_COUNTERS_EN
    if (is_counter(a)) return 1'b1;
`endif
    return m_csr.exists(a);
  endfunction

  function automatic bit [31:0] m_read(bit [11:0] a);
    case (a)
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ins[31:0];
      12'hB82: return m_ins[63:32];
      default: return m_csr[a];
    endcase
  endfunction

  task automatic model_reset();
    m_csr.delete(); m_mask.delete();
    m_csr[12'h300] = 32'h0000_1800; m_mask[12'h300] = 32'h0000_0088;
    m_csr[12'h301] = 32'h4000_0100; m_mask[12'h301] = 32'h0;
    m_csr[12'h305] = MTVEC_RST;     m_mask[12'h305] = 32'hFFFF_FFFC;
    m_csr[12'h340] = 32'h0;         m_mask[12'h340] = 32'hFFFF_FFFF;
    m_csr[12'h341] = 32'h0;         m_mask[12'h341] = 32'hFFFF_FFFC;
    m_csr[12'h342] = 32'h0;         m_mask[12'h342] = 32'h0000_000F;
    m_csr[12'hF14] = 32'h0;         m_mask[12'hF14] = 32'h0;
    m_cyc = 0; m_ins = 0; m_kill_rem = 0; m_redir = 0; m_rpc = '0;
  endtask

  // Compare this cycle's outputs at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    bit take, flsh, kill, known, ro, we, cyc_wr, ins_wr, mie;
    bit [31:0] old, nv;
    bit [11:0] a;
    @(negedge clk_core);
    a     = csr_addr;
    take  = (m_kill_rem == 0) && !wb_stall && wb_exc;
    flsh  = (m_kill_rem == 0) && !wb_stall && wb_valid && wb_flush && !wb_exc;
    kill  = take || flsh || (m_kill_rem > 0);
    known = m_known(a);
    ro    = known && !is_counter(a) && (m_mask[a] == 0);
    check_eq("kill", {31'd0, csr_kill}, {31'd0, kill});
    check_eq("illegal", {31'd0, csr_illegal}, {31'd0, !known || (ro && csr_op != CSR_READ)});
    if (known) check_eq("rdata", csr_rdata, m_read(a));
    check_eq("redirect", {31'd0, csr_redirect}, {31'd0, m_redir});
    check_eq("redirect_pc", {2'd0, csr_redirect_pc}, {2'd0, m_rpc});

    we = csr_req && !kill && known && !ro && csr_op != CSR_READ;
    old = known ? m_read(a) : 32'h0;
    case (csr_op)
      CSR_WRITE: nv = csr_wdata;
      CSR_SET:   nv = old | csr_wdata;
      CSR_CLEAR: nv = old & ~csr_wdata;
      default:   nv = old;
    endcase
    cyc_wr = 0; ins_wr = 0;
    if (we) begin
      case (a)
        12'hB00: begin m_cyc[31:0]  = nv; cyc_wr = 1; end
        12'hB80: begin m_cyc[63:32] = nv; cyc_wr = 1; end
        12'hB02: begin m_ins[31:0]  = nv; ins_wr = 1; end
        12'hB82: begin m_ins[63:32] = nv; ins_wr = 1; end
        default: m_csr[a] = (m_csr[a] & ~m_mask[a]) | (nv & m_mask[a]);
      endcase
    end
    if (!cyc_wr) m_cyc++;
    if (!ins_wr && wb_valid && !wb_stall && !kill) m_ins++;
    m_redir = 0;
    if (take) begin
      mie = m_csr[12'h300][3];
      m_csr[12'h300] = (m_csr[12'h300] & ~32'h88) | (mie ? 32'h80 : 32'h0);
      m_csr[12'h341] = {wb_pc, 2'b00};
      m_csr[12'h342] = 32'(wb_exc_cause);
      m_redir = 1;
      m_rpc   = m_csr[12'h305][31:2];
    end else if (flsh) begin
      m_redir = 1;
      m_rpc   = wb_pc + 30'd1;
    end
    if (take || flsh)        m_kill_rem = KC - 1;
    else if (m_kill_rem > 0) m_kill_rem--;
    @(posedge clk_core);
    #1;
  endtask

  task automatic set_idle();
    wb_valid = 0; wb_exc = 0; wb_flush = 0; wb_stall = 0;
    wb_exc_cause = EC_INSN_MISALIGN; wb_pc = '0;
    csr_req = 0; csr_op = CSR_READ; csr_addr = 12'h305; csr_wdata = '0;
  endtask

  task automatic csr_access(input csr_op_t op, input bit [11:0] a, input bit [31:0] d);
    csr_req = 1; csr_op = op; csr_addr = a; csr_wdata = d;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1;
    #1;
    model_reset();
    check_eq("rst_kill", {31'd0, csr_kill}, 32'd0);
    check_eq("rst_redirect", {31'd0, csr_redirect}, 32'd0);
    check_eq("rst_redirect_pc", {2'd0, csr_redirect_pc}, 32'd0);
    repeat (2) @(posedge clk_core);
    #1;
    reset = 0;
  endtask

  ecause_t   causes [6] = '{EC_INSN_ACCESS, EC_ILLEGAL_INSN, EC_BREAKPOINT,
                            EC_LOAD_ACCESS, EC_STORE_MISALIGN, EC_ECALL_M};
  bit [11:0] addrs [13] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'hF14,
                            12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'h7C0, 12'h344};

  initial begin
    reset = 1;
    do_reset();

    // Reset value of mtvec
    csr_access(CSR_READ, 12'h305, 0);
    #1 check_eq("mtvec_reset", csr_rdata, 32'h0000_0100);
    cycle();

    // Trap with MIE set
    csr_access(CSR_WRITE, 12'h300, 32'h8);
    cycle();
    set_idle();
    wb_exc = 1; wb_exc_cause = EC_ILLEGAL_INSN; wb_pc = 30'h400;
    cycle();
    set_idle();
    csr_access(CSR_READ, 12'h341, 0);
    #1;
    check_eq("trap_redirect", {31'd0, csr_redirect}, 32'd1);
    check_eq("trap_redirect_pc", {2'd0, csr_redirect_pc}, 32'h40);
    check_eq("trap_mepc", csr_rdata, 32'h1000);
    cycle();
    csr_access(CSR_READ, 12'h342, 0); cycle();
    csr_access(CSR_READ, 12'h300, 0);
    #1 check_eq("trap_mstatus", csr_rdata & 32'h88, 32'h80);
    cycle();

    // Flush at the top of the pc space wraps
    set_idle();
    wb_valid = 1; wb_flush = 1; wb_pc = 30'h3FFF_FFFF;
    cycle();
    set_idle();
    csr_access(CSR_READ, 12'h341, 0);
    #1 check_eq("flush_wrap_pc", {2'd0, csr_redirect_pc}, 32'h0);
    cycle();
    cycle();

    // Exception held off by stall
    set_idle();
    wb_exc = 1; wb_stall = 1; wb_exc_cause = EC_ECALL_M; wb_pc = 30'h123;
    for (int i = 0; i < 3; i++) begin
      #1 check_eq("stall_no_kill", {31'd0, csr_kill}, 32'd0);
      cycle();
    end
    wb_stall = 0;
    cycle();
    set_idle();
    repeat (3) cycle();

    // SET on mstatus colliding with a trap, then a second exception during KILL
    csr_access(CSR_WRITE, 12'h300, 32'h8); cycle();
    set_idle();
    wb_exc = 1; wb_exc_cause = EC_ILLEGAL_INSN; wb_pc = 30'h55;
    csr_access(CSR_SET, 12'h300, 32'h8);
    cycle();
    set_idle();
    wb_exc = 1; wb_exc_cause = EC_BREAKPOINT; wb_pc = 30'h77;
    csr_access(CSR_READ, 12'h300, 0);
    #1 check_eq("trap_wins_mie", {31'd0, csr_rdata[3]}, 32'd0);
    cycle();
    set_idle();
    csr_access(CSR_READ, 12'h342, 0);
    #1 check_eq("kill_ignores_exc", csr_rdata, 32'd2);
    cycle();

    // Reset while in KILL cancels the redirect
    set_idle();
    wb_exc = 1; wb_exc_cause = EC_LOAD_ACCESS; wb_pc = 30'h99;
    cycle();
    do_reset();
    cycle();

`ifdef CSR_COUNTERS_EN
    set_idle();
    csr_access(CSR_WRITE, 12'hB82, 32'h0); cycle();
    csr_access(CSR_WRITE, 12'hB02, 32'hFFFF_FFFF); cycle();
    set_idle();
    wb_valid = 1; cycle();
    set_idle();
    csr_access(CSR_READ, 12'hB82, 0);
    #1 check_eq("minstreth_carry", csr_rdata, 32'd1);
    cycle();
    csr_access(CSR_READ, 12'hB02, 0);
    #1 check_eq("minstret_wrap", csr_rdata, 32'd0);
    cycle();
`else
    set_idle();
    csr_access(CSR_READ, 12'hB02, 0);
    #1 check_eq("no_counters_illegal", {31'd0, csr_illegal}, 32'd1);
    cycle();
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        continue;
      end
      wb_valid     = ($urandom_range(0, 1) == 1);
      wb_exc       = ($urandom_range(0, 7) == 0);
      wb_flush     = ($urandom_range(0, 5) == 0);
      wb_stall     = ($urandom_range(0, 3) == 0);
      wb_exc_cause = causes[$urandom_range(0, 5)];
      wb_pc        = 30'($urandom);
      csr_req      = ($urandom_range(0, 1) == 1);
      csr_op       = csr_op_t'($urandom_range(0, 3));
      csr_addr     = addrs[$urandom_range(0, 12)];
      csr_wdata    = $urandom;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
